// File: rtl/sc_tei0026_pio_pkg.sv
// Shared register map and counter sizing for the sc_tei0026 debounced PIO block.
package sc_tei0026_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/sc_tei0026_pio_debounce.sv
// One-pin synchronizer and debouncer: two-flop sync, then a stability counter that
// accepts a new level only after DEBOUNCE_CYCLES consecutive differing samples.
module sc_tei0026_pio_debounce
  import sc_tei0026_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise
);

  localparam cnt_t CNT_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);

  logic r_sync1;
  logic r_sync2;
  logic r_level;
  cnt_t r_cnt;

  logic w_diff;
  logic w_accept;

  assign w_diff   = r_sync2 ^ r_level;
  // Last differing sample of the window: the level flips on this same edge.
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + cnt_t'(1);
      end
    end
  end

  assign o_level = r_level;
  // High in the cycle whose closing edge raises the level, so capture lands with it.
  assign o_rise  = w_accept & r_sync2;

endmodule

// File: rtl/sc_tei0026_pio_irq_ctrl.sv
// Avalon-MM input PIO with per-pin debounce, rising-edge capture and a masked,
// registered level interrupt.
module sc_tei0026_pio_irq_ctrl
  import sc_tei0026_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] w_level;
  logic [DATA_WIDTH-1:0] w_rise;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_bit
    sc_tei0026_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .i_pin   (in_port[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  logic [DATA_WIDTH-1:0] r_irqmask;
  logic [DATA_WIDTH-1:0] r_edgecap;
  logic [31:0]           r_readdata;
  logic                  r_irq;

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_irqmask_d;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [DATA_WIDTH-1:0] w_edgecap_d;
  logic [DATA_WIDTH-1:0] w_rsel;
  logic [31:0]           w_rdata;

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[DATA_WIDTH-1:0];

  if (DATA_WIDTH < 32) begin : g_wdata_hi
    logic w_unused_wdata;
    assign w_unused_wdata = ^writedata[31:DATA_WIDTH];
  end

  always_comb begin
    w_irqmask_d = r_irqmask;
    w_clr       = '0;
    if (w_wr && (address == ADDR_IRQMASK)) begin
      w_irqmask_d = w_wdata;
    end
    if (w_wr && (address == ADDR_EDGECAP)) begin
      w_clr = w_wdata;
    end
    // A fresh rise beats a simultaneous write-1-to-clear.
    w_edgecap_d = (r_edgecap & ~w_clr) | w_rise;
  end

  always_comb begin
    w_rsel = '0;
    unique case (address)
      ADDR_DATA:    w_rsel = w_level;
      ADDR_RSVD:    w_rsel = '0;
      ADDR_IRQMASK: w_rsel = r_irqmask;
      ADDR_EDGECAP: w_rsel = r_edgecap;
      default:      w_rsel = '0;
    endcase
    w_rdata = 32'(w_rsel);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask  <= '0;
      r_edgecap  <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irqmask  <= w_irqmask_d;
      r_edgecap  <= w_edgecap_d;
      r_readdata <= w_rdata;
      r_irq      <= |(r_edgecap & r_irqmask);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_sc_tei0026_pio_irq_ctrl.sv
// Directed self-checking bench for sc_tei0026_pio_irq_ctrl (DATA_WIDTH=3, DEBOUNCE_CYCLES=4).
module tb_sc_tei0026_pio_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [2:0]  in_port;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  sc_tei0026_pio_irq_ctrl #(
    .DATA_WIDTH      (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    tick();
    check(tag, readdata, exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 3'b000;
    #2;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    rd("idle_data", 2'd0, 32'h0);

    // Clean rise on bit0: level changes on the 6th edge, visible on readdata one edge later.
    in_port = 3'b001;
    repeat (6) tick();
    check("rise_data_e6", readdata, 32'h0);
    tick();
    check("rise_data_e7", readdata, 32'h1);
    rd("rise_edgecap", 2'd3, 32'h1);
    wr(2'd3, 32'h1);
    rd("clr_edgecap", 2'd3, 32'h0);

    // Bit1 glitch lasting three synced samples.
    in_port = 3'b011;
    repeat (3) tick();
    in_port = 3'b001;
    repeat (10) tick();
    rd("glitch_data", 2'd0, 32'h1);
    rd("glitch_edgecap", 2'd3, 32'h0);

    // Masked interrupt on bit2.
    wr(2'd2, 32'h4);
    address = 2'd3;
    in_port = 3'b101;
    repeat (6) tick();
    check("irq_e6", {31'b0, irq}, 32'h0);
    check("edgecap_e6", readdata, 32'h0);
    tick();
    check("irq_e7", {31'b0, irq}, 32'h1);
    check("edgecap_e7", readdata, 32'h4);
    wr(2'd3, 32'h4);
    check("irq_at_clr", {31'b0, irq}, 32'h1);
    tick();
    check("irq_after_clr", {31'b0, irq}, 32'h0);

    // Falling edge ignored, then clear collides with a new rise on bit0.
    in_port = 3'b100;
    repeat (10) tick();
    rd("fall_edgecap", 2'd3, 32'h0);
    rd("fall_data", 2'd0, 32'h4);
    in_port = 3'b101;
    repeat (5) tick();
    wr(2'd3, 32'h1);
    rd("setwins_edgecap", 2'd3, 32'h1);
    rd("setwins_data", 2'd0, 32'h5);

    // Mask change takes effect on irq one cycle after the write edge.
    check("irq_masked", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h1);
    check("irq_mask_edge", {31'b0, irq}, 32'h0);
    tick();
    check("irq_unmasked", {31'b0, irq}, 32'h1);

    // Register map corner cases.
    wr(2'd2, 32'hFFFF_FFFF);
    rd("mask_readback", 2'd2, 32'h7);
    rd("rsvd_read", 2'd1, 32'h0);
    wr(2'd0, 32'hFFFF_FFFF);
    rd("data_ro", 2'd0, 32'h5);

    // Reset mid-count: everything clears at once, then pins high debounce as fresh rises.
    address = 2'd2;
    in_port = 3'b111;
    repeat (3) tick();
    check("pre_rst_readdata", readdata, 32'h7);
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    repeat (2) tick();
    address = 2'd3;
    reset_n = 1'b1;
    repeat (6) tick();
    check("post_rst_edgecap_e6", readdata, 32'h0);
    tick();
    check("post_rst_edgecap_e7", readdata, 32'h7);
    rd("post_rst_data", 2'd0, 32'h7);
    rd("post_rst_mask", 2'd2, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
